// File: rtl/ifm_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ifm_loader
// Description : Input-feature-map loader. Issues one read-master request per
//               operation and packs PACK returned stream beats (first beat in
//               the LSBs) into one OUTPUT_WIDTH word. It buffers packed words
//               in a FIFO and presents them to the PE array as a push-style
//               valid port that honours g_stall.
// Ports       : clk, rst_n            clock, asynchronous active-low reset
//               op_start, ifm_size,   operation start, byte size and base
//               rmst_offset           address
//               rmst_req/addr/xfer    one-cycle read-master request + args
//               rmst_done             read-master completion pulse
//               tdata/tvalid/tready   inbound AXI-stream beats
//               ifm_port/ifm_port_v   packed word to the array (popped when
//                                     valid), gated by g_stall
//               read_buffer_wait      busy from accepted op_start to done
//               done                  one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module ifm_loader #(
    parameter int FIFO_ADDR_WIDTH = 4,
    parameter int INPUT_WIDTH     = 512,
    parameter int OUTPUT_WIDTH    = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    g_stall,
    input  logic                    op_start,
    input  logic [31:0]             ifm_size,
    input  logic [63:0]             rmst_offset,
    output logic                    rmst_req,
    output logic [63:0]             rmst_addr,
    output logic [63:0]             rmst_xfer_size,
    input  logic                    rmst_done,
    input  logic [INPUT_WIDTH-1:0]  tdata,
    input  logic                    tvalid,
    output logic                    tready,
    output logic [OUTPUT_WIDTH-1:0] ifm_port,
    output logic                    ifm_port_v,
    output logic                    read_buffer_wait,
    output logic                    done
);

    localparam int PACK         = OUTPUT_WIDTH / INPUT_WIDTH;
    localparam int c_beat_bytes = INPUT_WIDTH / 8;
    localparam int c_word_shift = $clog2(PACK * c_beat_bytes);
    localparam int c_slice_w    = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int c_depth      = 1 << FIFO_ADDR_WIDTH;
    localparam logic [c_slice_w-1:0] c_last_slice = c_slice_w'(PACK - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t                   r_state;
    logic [31:0]              r_beats;
    logic [31:0]              r_beat_cnt;
    logic [c_slice_w-1:0]     r_slice;
    logic [OUTPUT_WIDTH-1:0]  r_asm;
    logic [OUTPUT_WIDTH-1:0]  r_word;
    logic                     r_pending;
    logic                     r_done_seen;
    logic [FIFO_ADDR_WIDTH:0] r_wr_ptr;
    logic [FIFO_ADDR_WIDTH:0] r_rd_ptr;
    logic [OUTPUT_WIDTH-1:0]  r_mem [c_depth];

    logic [31:0]             w_words;
    logic [31:0]             w_xfer_bytes;
    logic [31:0]             w_beats;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_hold;
    logic                    w_beat;
    logic [OUTPUT_WIDTH-1:0] w_asm_next;

    // Residual bytes that do not fill a whole packed word are dropped.
    assign w_words      = ifm_size >> c_word_shift;
    assign w_xfer_bytes = w_words << c_word_shift;
    assign w_beats      = w_words * 32'(PACK);

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[FIFO_ADDR_WIDTH] != r_rd_ptr[FIFO_ADDR_WIDTH]) &&
                     (r_wr_ptr[FIFO_ADDR_WIDTH-1:0] == r_rd_ptr[FIFO_ADDR_WIDTH-1:0]);

    assign w_pop  = !w_empty && !g_stall;
    // A full FIFO still takes the word if a pop frees a slot this cycle.
    assign w_push = r_pending && (!w_full || w_pop);
    // Completed word stuck behind a full FIFO: stop taking beats so nothing
    // is overwritten while it waits.
    assign w_hold = r_pending && !w_push;

    assign tready = (r_state == ST_STREAM) && (r_beat_cnt < r_beats) && !w_hold;
    assign w_beat = tvalid && tready;

    assign ifm_port_v = w_pop;
    assign ifm_port   = w_empty ? '0 : r_mem[r_rd_ptr[FIFO_ADDR_WIDTH-1:0]];

    // Partial word with the incoming beat merged into its slice.
    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[int'(r_slice) * INPUT_WIDTH +: INPUT_WIDTH] = tdata;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= r_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            rmst_req         <= 1'b0;
            rmst_addr        <= '0;
            rmst_xfer_size   <= '0;
            read_buffer_wait <= 1'b0;
            done             <= 1'b0;
            r_beats          <= '0;
            r_beat_cnt       <= '0;
            r_slice          <= '0;
            r_asm            <= '0;
            r_word           <= '0;
            r_pending        <= 1'b0;
            r_done_seen      <= 1'b0;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
        end else begin
            rmst_req <= 1'b0;
            done     <= 1'b0;

            // Busy flag drops together with the end of the done pulse.
            if (done) begin
                read_buffer_wait <= 1'b0;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (FIFO_ADDR_WIDTH + 1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (FIFO_ADDR_WIDTH + 1)'(1);
            end

            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 32'd1;
                r_asm      <= w_asm_next;
                if (r_slice == c_last_slice) begin
                    r_slice <= '0;
                    r_word  <= w_asm_next;
                end else begin
                    r_slice <= r_slice + c_slice_w'(1);
                end
            end

            if (w_beat && (r_slice == c_last_slice)) begin
                r_pending <= 1'b1;
            end else if (w_push) begin
                r_pending <= 1'b0;
            end

            // Completion may arrive at any time after the request.
            if (rmst_done && (r_state == ST_REQ || r_state == ST_STREAM ||
                              r_state == ST_DRAIN)) begin
                r_done_seen <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    // The done-pulse cycle itself is not a start slot.
                    if (op_start && !done) begin
                        rmst_addr        <= rmst_offset;
                        rmst_xfer_size   <= {32'd0, w_xfer_bytes};
                        read_buffer_wait <= 1'b1;
                        r_beats          <= w_beats;
                        r_beat_cnt       <= '0;
                        r_slice          <= '0;
                        r_done_seen      <= 1'b0;
                        if (w_words == 32'd0) begin
                            r_state <= ST_FINISH;
                        end else begin
                            rmst_req <= 1'b1;
                            r_state  <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if ((r_beat_cnt == r_beats) && !r_pending) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_empty && r_done_seen) begin
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    done        <= 1'b1;
                    r_done_seen <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ifm_loader.md
Name: ifm_loader

Overview:
- Read-side counterpart of the output-map writer. Issues one read-master transfer per operation and accepts the returned 512-bit AXI-stream beats.
- Packs PACK consecutive beats into one OUTPUT_WIDTH input-feature-map word.
- Buffers packed words in an internal FIFO and presents them to the conv array as a push-style valid port, with back-pressure from g_stall.
- Sits between the read master and the PE-array input (ifm_port).

Parameters:
- FIFO_ADDR_WIDTH, 4, log2 depth of the packed-word FIFO (16 entries).
- INPUT_WIDTH, 512, stream beat width in bits (64 bytes).
- OUTPUT_WIDTH, 1024, packed word width. Must be an integer multiple of INPUT_WIDTH.
- PACK, OUTPUT_WIDTH/INPUT_WIDTH, beats per packed word (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- g_stall  in  1  array stall; when high, no packed word is presented
- op_start  in  1  single-cycle operation start
- ifm_size  in  32  transfer size in bytes
- rmst_offset  in  64  read base address
- rmst_req  out  1  single-cycle read-master request
- rmst_addr  out  64  latched read address
- rmst_xfer_size  out  64  latched size, zero-extended
- rmst_done  in  1  read-master completion pulse
- tdata  in  INPUT_WIDTH  stream data
- tvalid  in  1  stream valid
- tready  out  1  stream ready
- ifm_port  out  OUTPUT_WIDTH  packed word
- ifm_port_v  out  1  packed word valid; consumed in the same cycle
- read_buffer_wait  out  1  high from accepted op_start until done
- done  out  1  single-cycle completion pulse

Behaviour:
- Reset (asynchronous, active-low rst_n; clock clk) drives all of the following to 0: rmst_req, rmst_addr, rmst_xfer_size, tready, ifm_port_v, ifm_port, read_buffer_wait, done, all counters, FIFO state and state=IDLE.
- words = ifm_size >> log2(PACK*64). Residual bytes are ignored. beats = words*PACK.
- IDLE, on op_start:
  - latch rmst_addr <= rmst_offset and rmst_xfer_size <= {32'b0, words*PACK*64};
  - set read_buffer_wait.
  - If words==0: go to FINISH, with no rmst_req.
  - Otherwise: go to REQ.
- op_start in any state other than IDLE is ignored.
- REQ: rmst_req=1 for exactly one cycle, then go to STREAM.
- STREAM:
  - tready = (beat_cnt < beats) && !hold.
  - A beat is accepted on tvalid&tready. Beat k is written to slice [(k mod PACK)*INPUT_WIDTH +: INPUT_WIDTH], so the first beat lands in the LSBs.
  - When slice PACK-1 is written, the assembled word is pushed to the FIFO in the next cycle.
  - If the FIFO is full, hold=1. tready stays low until the push succeeds. No beat is ever dropped or overwritten.
  - Beats offered after beat_cnt==beats are not accepted (tready=0).
- rmst_done is latched (done_seen) in any state after REQ, so it may arrive before, during or after the last beat.
- STREAM -> DRAIN when beat_cnt==beats and the last word has been pushed.
- DRAIN -> FINISH when FIFO is empty and done_seen is set.
- FINISH: done=1 for one cycle; read_buffer_wait <= 0; clear done_seen; go to IDLE.
- Output side:
  - ifm_port_v = !fifo_empty && !g_stall.
  - ifm_port = FIFO head. It is combinational from FIFO storage and must be valid in the same cycle as ifm_port_v.
  - A pop occurs whenever ifm_port_v=1.
- Simultaneous push and pop are allowed when the FIFO is full or empty. For an empty-FIFO push, the word appears on ifm_port_v the cycle after the push, giving 1-cycle latency from push to availability.
- Latency: last beat of a word accepted at cycle t -> ifm_port_v at t+2 if not stalled.
- Back-to-back operations: op_start is accepted the cycle after done.
- Mid-operation reset: everything returns to reset values immediately and no pending request is re-issued.

Test Plan:
- ifm_size=256, rmst_offset=0x1000, tvalid always high, g_stall=0 -> rmst_req one pulse with rmst_addr=0x1000 and rmst_xfer_size=256. Two ifm_port_v pulses: word0={beat1,beat0}, word1={beat3,beat2}. With rmst_done given after beat 3, done pulses once FIFO empty; read_buffer_wait falls with done.
- ifm_size=64*2*20, g_stall held high throughout the stream -> FIFO reaches 16 entries. tready goes low while the 17th word is held. Release g_stall -> all 20 words come out in order with none lost, and tready resumes.
- rmst_done pulsed before the first beat, ifm_size=128 -> done_seen is latched. done pulses only after the single word is popped.
- ifm_size=100 -> words=0, no rmst_req, done one cycle after FINISH is reached, read_buffer_wait high for 2 cycles.
- Random tvalid gaps (50%) plus random g_stall, 8 words -> the packed sequence matches the reference model bit-exact, and tready=0 after the 16th beat even with tvalid high.
- Assert rst_n low in STREAM after 3 beats, then a new op_start -> outputs are 0 during reset and the new operation starts cleanly with beat index 0.
